iis_write_logic: RTL
====================

IIS_WRITE_LOGIC -- requirements
Module: iis_write_logic

Interface
REQ-001 SHALL have no parameters; fixed ratios are bclk = clk_100m/32 (3.125 MHz), lrclk = clk_100m/2048 (48.828 kHz), 24-bit samples, 32 bclk slots per channel.
REQ-002 clk_100m  input  1  system clock, all logic on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ldata_i  input  24  left sample, two's complement, MSB first on the wire.
REQ-005 rdata_i  input  24  right sample.
REQ-006 data_valid  input  1  ldata_i/rdata_i hold a frame.
REQ-007 data_ready  output  1  holding register empty, frame accepted when valid&&ready.
REQ-008 bclk  output  1  I2S bit clock.
REQ-009 lrclk  output  1  word select: 0 = left, 1 = right.
REQ-010 sdata_o  output  1  I2S serial data.
REQ-011 underrun  output  1  one-cycle pulse, frame started with no new data.

Function
REQ-012 SHALL keep one free-running 11-bit counter cnt, incremented every cycle, wrapping 2047->0.
REQ-013 bclk SHALL equal cnt[4] and lrclk SHALL equal cnt[10], both driven directly from registered bits.
REQ-014 slot index SHALL be cnt[9:5] (0..31) within each half-frame.
REQ-015 I2S one-bit delay: slot 0 SHALL drive 0, slots 1..24 SHALL drive bits 23..0, slots 25..31 SHALL drive 0.
REQ-016 sdata_o SHALL be registered and SHALL change on the same clk_100m edge as the bclk falling edge, so it is stable across every bclk rising edge (receiver samples on rising edge).
REQ-017 Holding register (48 bits plus full flag) SHALL load on valid&&ready, and data_ready SHALL equal !full.
REQ-018 Frame start SHALL be the edge where cnt wraps 2047->0; on that edge, if full, frame registers SHALL load from holding and full SHALL clear, so data_ready rises one cycle later.
REQ-019 If holding is empty at frame start, underrun SHALL pulse high for exactly one cycle and the frame SHALL follow REQ-030/031.
REQ-020 If valid&&ready occurs on the frame-start edge itself, holding SHALL capture the data, that frame SHALL be an underrun, and the data SHALL be sent at the next frame start.
REQ-021 Left and right SHALL always come from the same accepted frame; there SHALL be no channel slip.
REQ-022 data_valid while !data_ready SHALL be ignored, and holding contents SHALL never be overwritten.
REQ-023 Frame registers SHALL stay constant for the full 2048 cycles of a frame.

Reset
REQ-024 On rst_n low: cnt=0, bclk=0, lrclk=0, sdata_o=0, underrun=0.
REQ-025 On rst_n low: holding empty, data_ready=1, frame registers=0.
REQ-026 The frame that begins at reset release SHALL transmit zeros and SHALL NOT flag underrun.
REQ-027 Reset asserted mid-frame SHALL abort immediately, with no partial word completed after release.
REQ-028 After release, the first lrclk rising edge SHALL occur 1024 cycles later.

Configuration
REQ-029 SHALL use macro IIS_TX_ZERO_ON_UNDERRUN_EN to select underrun behaviour.
REQ-030 With IIS_TX_ZERO_ON_UNDERRUN_EN defined: on underrun, frame registers SHALL load 0 (silence).
REQ-031 Without it: on underrun, frame registers SHALL retain the previous frame (repeat last sample).
REQ-032 underrun pulse generation SHALL be identical in both builds.

Verification
REQ-033 Reset: hold rst_n low 10 cycles -> all outputs 0 and data_ready=1; after release, bclk period 32 cycles and lrclk period 2048 cycles, 50% duty.
REQ-034 Single frame: push L=0xA5A5A5, R=0x5A5A5A before first wrap -> next frame carries 0xA5A5A5 on rising bclk edges of left slots 1..24 and 0x5A5A5A in right slots 1..24; slots 0 and 25..31 read 0; underrun stays 0.
REQ-035 Back-pressure: hold valid high with incrementing data -> exactly one accept per 2048 cycles, data_ready low between accepts, no frame lost or duplicated.
REQ-036 Underrun: send 0x123456/0x654321 once, then stop -> underrun pulses once per subsequent frame; line shows zeros (macro defined) or repeated 0x123456/0x654321 (macro undefined).
REQ-037 Simultaneous: valid&&ready on the wrap edge -> underrun=1 that cycle, and the data appears one frame later.
REQ-038 Reset mid-right-channel -> sdata_o=0 immediately; after release, counter restarts at 0 and the frame is zeros.

Source files
------------

// File: rtl/iis_write_logic.sv
// I2S transmitter: 100 MHz in, bclk = /32, lrclk = /2048, 24-bit samples left-justified one bit after lrclk.
// Underrun behaviour selected by IIS_TX_ZERO_ON_UNDERRUN_EN (defined: send silence, undefined: repeat last frame).
module iis_write_logic (
   input  logic        clk_100m,
   input  logic        rst_n,
   input  logic [23:0] ldata_i,
   input  logic [23:0] rdata_i,
   input  logic        data_valid,
   output logic        data_ready,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata_o,
   output logic        underrun
);

   typedef struct packed {
      logic [23:0] l;
      logic [23:0] r;
   } frame_t;

   logic [10:0] cnt;
   logic [10:0] cnt_nxt;
   logic        wrap;
   logic        accept;
   logic        full;
   frame_t      hold_q;
   frame_t      frame_q;
   logic [4:0]  slot_n;
   logic [23:0] word_n;
   logic        bit_n;

   assign cnt_nxt    = cnt + 11'd1;
   assign wrap       = (cnt == 11'h7ff);
   assign accept     = data_valid && !full;
   assign data_ready = !full;
   assign bclk       = cnt[4];
   assign lrclk      = cnt[10];

   // Bit for the slot that begins on the next bclk falling edge.
   assign slot_n = cnt_nxt[9:5];
   assign word_n = cnt_nxt[10] ? frame_q.r : frame_q.l;

   always_comb begin
      bit_n = 1'b0;
      if (slot_n >= 5'd1 && slot_n <= 5'd24)
         bit_n = word_n[5'd24 - slot_n];
   end

   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         sdata_o  <= 1'b0;
         underrun <= 1'b0;
      end else begin
         cnt      <= cnt_nxt;
         underrun <= wrap && !full;
         if (cnt[4:0] == 5'd31)
            sdata_o <= bit_n;
      end
   end

   // A frame accepted on the wrap edge itself lands in holding and waits a full frame.
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         full    <= 1'b0;
         hold_q  <= '0;
         frame_q <= '0;
      end else begin
         if (wrap && full) begin
            frame_q <= hold_q;
            full    <= 1'b0;
         end else begin
`ifdef IIS_TX_ZERO_ON_UNDERRUN_EN
            if (wrap)
               frame_q <= '0;
`endif
            if (accept) begin
               hold_q <= '{l: ldata_i, r: rdata_i};
               full   <= 1'b1;
            end
         end
      end
   end

endmodule
